fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS datapath. It generalises EX-stage operand forwarding to NUM_SRC sources and NUM_FWD downstream result stages with nearest-stage priority. It adds load-use stall detection and a multi-cycle MUL/DIV busy tracker (FSM plus down-counter) that stalls dependent instructions in ID. It also keeps a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline registers and drives the EX operand muxes plus the PC, IF/ID and ID/EX control.

## Interface
Parameters:
- ADDR_W, 5, register-address width
- NUM_SRC, 2, source operands per instruction (src 0 = Rs, src 1 = Rt)
- NUM_FWD, 2, forwarding stages after EX; stage 1 = M (nearest), stage NUM_FWD = WB
- MD_LAT, 4, MUL/DIV latency in cycles, counted from the EX start cycle; must be ≥2
- CNT_W, 16, stall-counter width

Ports (the interface uses one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ID_src  in  NUM_SRC*ADDR_W  ID-stage source registers, src i at [i*ADDR_W +: ADDR_W]
- ID_use  in  NUM_SRC  ID source i is actually read
- ID_is_md  in  1  ID instruction is MUL/DIV
- EX_src  in  NUM_SRC*ADDR_W  EX-stage source registers
- EX_RegWrite  in  1  EX instruction writes a register
- EX_MemRead  in  1  EX instruction is a load
- EX_WR  in  ADDR_W  EX destination
- EX_md_start  in  1  MUL/DIV issues in EX this cycle
- FWD_RegWrite  in  NUM_FWD  per-stage write enable, bit k-1 = stage k
- FWD_WR  in  NUM_FWD*ADDR_W  per-stage destination
- fwd_sel  out  NUM_SRC*$clog2(NUM_FWD+1)  per-source select: 0 = register file, k = stage k
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control next edge
- md_busy  out  1  MUL/DIV in flight
- stall_cnt  out  CNT_W  cycles with stall=1, saturating

## Operation
- Forwarding: for each src i, fwd_sel[i] = smallest k where FWD_RegWrite[k-1] && FWD_WR[k] != 0 && FWD_WR[k] == EX_src[i]. Otherwise 0. Register 0 is never forwarded.
- Load-use hazard: EX_MemRead && EX_RegWrite && EX_WR != 0 && some i with ID_use[i] && ID_src[i] == EX_WR.
- FSM states are IDLE and MD_BUSY, with registered md_dest (ADDR_W) and md_cnt ($clog2(MD_LAT)).
  - IDLE → MD_BUSY on EX_md_start. Load md_dest = EX_WR and md_cnt = MD_LAT-1.
  - In MD_BUSY, md_cnt decrements each cycle. Leave to IDLE on the edge where md_cnt == 1.
  - EX_md_start while in MD_BUSY reloads md_dest and md_cnt and stays in MD_BUSY.
- md_busy = (state == MD_BUSY).
- MD hazard: md_busy && (ID_is_md || some i with ID_use[i] && md_dest != 0 && ID_src[i] == md_dest).
- stall = bubble = load-use hazard OR MD hazard.
- stall_cnt increments by 1 on each edge with stall=1 and holds at all-ones.

## Timing
- fwd_sel, stall and bubble are combinational from the current inputs and registered state, with zero-cycle latency.
- A load-use hazard produces exactly 1 stall cycle, since the load advances to M on the next edge.
- MUL/DIV started in EX at cycle t: md_busy is 1 in cycles t+1 … t+MD_LAT-1, then 0. A dependent ID instruction stalls through cycle t+MD_LAT-1 and proceeds at t+MD_LAT.
- Reset values: state IDLE, md_cnt 0, md_dest 0, stall_cnt 0, md_busy 0. With zero inputs, fwd_sel = 0, stall = 0 and bubble = 0.
- rst asserted mid-MUL/DIV clears the FSM immediately (asynchronously). No stall follows after release.
- When a load-use hazard and an MD hazard coincide, stall is a single asserted signal and stall_cnt increments once per cycle.

## Structure
- Shared package hazard_pkg holds the FSM state typedef (IDLE, MD_BUSY) and the fwd_sel encoding constants (FWD_RF = 0).
- Sub-module fwd_match: one instance per source. It contains the priority match of one EX source against all NUM_FWD stages and outputs that source's select.
- The top level holds the hazard logic, the FSM/counter and stall_cnt.

## Test plan
- Defaults: EX_src = {7,5}; stage 1 writes r5 and stage 2 writes r5 and r7 → fwd_sel src0 = 1 (nearest wins), src1 = 2.
- Stage 1 writes r0 with RegWrite=1 and EX_src0 = 0 → fwd_sel src0 = 0. Stage 1 RegWrite=0 with a matching address → no forwarding.
- EX load to r3 and ID uses r3 → stall = bubble = 1 for 1 cycle. stall_cnt goes 0→1. With ID_use cleared → no stall.
- EX_md_start with EX_WR = 9 and MD_LAT = 4 at cycle t, ID reads r9 → md_busy and stall high in t+1…t+3, low at t+4. stall_cnt = 3.
- md_busy with ID_is_md=1 → stall. Assert rst in cycle t+2 → md_busy = 0 and stall = 0 immediately. After release, state is IDLE.
- CNT_W = 2 with stall held for 5 cycles → stall_cnt saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the forwarding/hazard unit.
//   md_state_e - MUL/DIV tracker states (IDLE, MD_BUSY)
//   FWD_RF     - fwd_sel value meaning "take operand from the register file"
package hazard_pkg;
    typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;
    localparam int FWD_RF = 0;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority match of one EX source against all downstream result stages.
//   src_i - EX source register address
//   we_i  - per-stage write enable, bit k-1 = stage k
//   wr_i  - per-stage destination, stage k at [(k-1)*ADDR_W +: ADDR_W]
//   sel_o - FWD_RF, or the nearest stage k holding a newer value of src_i
module fwd_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [ADDR_W-1:0]         src_i,
    input  logic [NUM_FWD-1:0]        we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] wr_i,
    output logic [SEL_W-1:0]          sel_o
);
    // Scan farthest to nearest so the nearest matching stage is written last and wins.
    always_comb begin
        sel_o = SEL_W'(FWD_RF);
        for (int k = NUM_FWD; k >= 1; k--)
            if (we_i[k-1] && wr_i[(k-1)*ADDR_W +: ADDR_W] != '0 && wr_i[(k-1)*ADDR_W +: ADDR_W] == src_i)
                sel_o = SEL_W'(k);
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, load-use and MUL/DIV stall detection, stall counter.
//   clk, rst          - clock, asynchronous active-high reset
//   ID_src/ID_use     - ID source registers and their read flags
//   ID_is_md          - ID instruction is MUL/DIV
//   EX_src            - EX source registers to be forwarded
//   EX_RegWrite/EX_MemRead/EX_WR - EX write enable, load flag, destination
//   EX_md_start       - MUL/DIV issues in EX this cycle
//   FWD_RegWrite/FWD_WR - downstream stage write enables and destinations
//   fwd_sel           - per-source operand select (0 = register file, k = stage k)
//   stall/bubble      - hold PC and IF/ID, zero ID/EX control
//   md_busy           - MUL/DIV in flight
//   stall_cnt         - saturating count of stalled cycles
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MD_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SRC*ADDR_W-1:0]             ID_src,
    input  logic [NUM_SRC-1:0]                    ID_use,
    input  logic                                  ID_is_md,
    input  logic [NUM_SRC*ADDR_W-1:0]             EX_src,
    input  logic                                  EX_RegWrite,
    input  logic                                  EX_MemRead,
    input  logic [ADDR_W-1:0]                     EX_WR,
    input  logic                                  EX_md_start,
    input  logic [NUM_FWD-1:0]                    FWD_RegWrite,
    input  logic [NUM_FWD*ADDR_W-1:0]             FWD_WR,
    output logic [NUM_SRC*$clog2(NUM_FWD+1)-1:0]  fwd_sel,
    output logic                                  stall,
    output logic                                  bubble,
    output logic                                  md_busy,
    output logic [CNT_W-1:0]                      stall_cnt
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int CW    = $clog2(MD_LAT);

    md_state_e         state_q, state_d;
    logic [ADDR_W-1:0] md_dest_q, md_dest_d;
    logic [CW-1:0]     md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              lu_hit, md_hit, lu_haz, md_haz;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_match #(.ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd (
            .src_i (EX_src[i*ADDR_W +: ADDR_W]),
            .we_i  (FWD_RegWrite),
            .wr_i  (FWD_WR),
            .sel_o (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        lu_hit = 1'b0;
        md_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lu_hit |= ID_use[i] && ID_src[i*ADDR_W +: ADDR_W] == EX_WR;
            md_hit |= ID_use[i] && ID_src[i*ADDR_W +: ADDR_W] == md_dest_q;
        end
        lu_haz = EX_MemRead && EX_RegWrite && EX_WR != '0 && lu_hit;
        md_haz = md_busy && (ID_is_md || (md_dest_q != '0 && md_hit));
    end

    assign md_busy   = state_q == MD_BUSY;
    assign stall     = lu_haz || md_haz;
    assign bubble    = stall;
    assign stall_cnt = stall_cnt_q;

    // A new MUL/DIV always reloads; otherwise the busy counter runs down and drops to IDLE at 1.
    always_comb begin
        state_d     = EX_md_start ? MD_BUSY : (md_busy && md_cnt_q == CW'(1)) ? IDLE : state_q;
        md_dest_d   = EX_md_start ? EX_WR : md_dest_q;
        md_cnt_d    = EX_md_start ? CW'(MD_LAT - 1) : md_busy ? md_cnt_q - 1'b1 : md_cnt_q;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            md_dest_q   <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_dest_q   <= md_dest_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and randomized checks of fwd_hazard_unit against a behavioural model.
module tb_fwd_hazard_unit;
    localparam int AW = 5, NS = 2, NF = 2, LAT = 4, CW = 16;
    localparam int SW = $clog2(NF + 1);

    logic clk = 1'b0;
    logic rst;
    logic [NS*AW-1:0] ID_src, EX_src;
    logic [NS-1:0]    ID_use;
    logic             ID_is_md, EX_RegWrite, EX_MemRead, EX_md_start;
    logic [AW-1:0]    EX_WR;
    logic [NF-1:0]    FWD_RegWrite;
    logic [NF*AW-1:0] FWD_WR;
    logic [NS*SW-1:0] fwd_sel, fwd_sel2;
    logic             stall, bubble, md_busy, stall2, bubble2, md_busy2;
    logic [CW-1:0]    stall_cnt;
    logic [1:0]       stall_cnt2;

    int errors = 0, checks = 0;
    int cyc = 0, md_st = 0, scnt = 0, scnt2 = 0;
    bit md_valid = 1'b0;
    logic [AW-1:0] m_dest = '0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF), .MD_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ID_src(ID_src), .ID_use(ID_use), .ID_is_md(ID_is_md),
        .EX_src(EX_src), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WR(EX_WR),
        .EX_md_start(EX_md_start), .FWD_RegWrite(FWD_RegWrite), .FWD_WR(FWD_WR),
        .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .md_busy(md_busy), .stall_cnt(stall_cnt));

    fwd_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF), .MD_LAT(LAT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ID_src(ID_src), .ID_use(ID_use), .ID_is_md(ID_is_md),
        .EX_src(EX_src), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WR(EX_WR),
        .EX_md_start(EX_md_start), .FWD_RegWrite(FWD_RegWrite), .FWD_WR(FWD_WR),
        .fwd_sel(fwd_sel2), .stall(stall2), .bubble(bubble2), .md_busy(md_busy2), .stall_cnt(stall_cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MUL/DIV started at cycle st is in flight during cycles st+1 .. st+LAT-1.
    function automatic bit m_busy();
        return md_valid && cyc > md_st && cyc <= md_st + LAT - 1;
    endfunction

    function automatic int m_sel(input int i);
        for (int k = 1; k <= NF; k++)
            if (FWD_RegWrite[k-1] && FWD_WR[(k-1)*AW +: AW] != 0 && FWD_WR[(k-1)*AW +: AW] == EX_src[i*AW +: AW])
                return k;
        return 0;
    endfunction

    function automatic bit m_stall();
        bit lu = 1'b0, mh = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (ID_use[i] && ID_src[i*AW +: AW] == EX_WR) lu = 1'b1;
            if (ID_use[i] && m_dest != 0 && ID_src[i*AW +: AW] == m_dest) mh = 1'b1;
        end
        return (EX_MemRead && EX_RegWrite && EX_WR != 0 && lu) || (m_busy() && (ID_is_md || mh));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_valid = 1'b0;
            m_dest   = '0;
            scnt     = 0;
            scnt2    = 0;
        end else if (clk) begin
            if (m_stall()) begin
                scnt  = (scnt < (1 << CW) - 1) ? scnt + 1 : scnt;
                scnt2 = (scnt2 < 3) ? scnt2 + 1 : scnt2;
            end
            if (!m_busy()) m_dest = '0;
            if (EX_md_start) begin
                md_valid = 1'b1;
                md_st    = cyc;
                m_dest   = EX_WR;
            end
        end
        if (clk) cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*SW +: SW]), 32'(m_sel(i)));
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("bubble", 32'(bubble), 32'(m_stall()));
        chk("md_busy", 32'(md_busy), 32'(m_busy()));
        chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
        chk("stall_cnt_w2", 32'(stall_cnt2), 32'(scnt2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ID_src = '0; ID_use = '0; ID_is_md = 1'b0; EX_src = '0; EX_RegWrite = 1'b0;
        EX_MemRead = 1'b0; EX_WR = '0; EX_md_start = 1'b0; FWD_RegWrite = '0; FWD_WR = '0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst fwd_sel", 32'(fwd_sel), 0);
        chk("rst stall", 32'(stall), 0);
        chk("rst bubble", 32'(bubble), 0);
        chk("rst md_busy", 32'(md_busy), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);

        tick();
        EX_src = {5'd7, 5'd5}; FWD_RegWrite = 2'b11; FWD_WR = {5'd7, 5'd5};
        #2 chk("fwd split", 32'(fwd_sel), 32'h9);
        tick();
        FWD_WR = {5'd5, 5'd5};
        #2 chk("fwd nearest", 32'(fwd_sel), 32'h1);
        tick();
        EX_src = {5'd9, 5'd0}; FWD_WR = {5'd9, 5'd0};
        #2 chk("fwd r0", 32'(fwd_sel), 32'h8);
        tick();
        EX_src = {5'd1, 5'd5}; FWD_RegWrite = 2'b10; FWD_WR = {5'd1, 5'd5};
        #2 chk("fwd no we", 32'(fwd_sel), 32'h8);

        tick();
        clr();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WR = 5'd3; ID_src = {5'd0, 5'd3}; ID_use = 2'b01;
        #2;
        chk("lu stall", 32'(stall), 1);
        chk("lu bubble", 32'(bubble), 1);
        tick();
        clr();
        #2;
        chk("lu one cycle", 32'(stall), 0);
        chk("lu cnt", 32'(stall_cnt), 1);
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WR = 5'd3; ID_src = {5'd0, 5'd3};
        #1 chk("lu no use", 32'(stall), 0);

        tick();
        clr();
        EX_md_start = 1'b1; EX_WR = 5'd9; ID_src = {5'd0, 5'd9}; ID_use = 2'b01;
        #2 chk("md t busy", 32'(md_busy), 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            EX_md_start = 1'b0; EX_WR = '0;
            #2;
            chk($sformatf("md busy t+%0d", c), 32'(md_busy), 32'(c < 4));
            chk($sformatf("md stall t+%0d", c), 32'(stall), 32'(c < 4));
        end
        chk("md cnt", 32'(stall_cnt), 4);

        tick();
        clr();
        EX_md_start = 1'b1; EX_WR = 5'd9; ID_is_md = 1'b1;
        tick();
        EX_md_start = 1'b0;
        #2;
        chk("md_is_md stall", 32'(stall), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("arst md_busy", 32'(md_busy), 0);
        chk("arst stall", 32'(stall), 0);
        chk("arst cnt", 32'(stall_cnt), 0);
        tick();
        rst = 1'b0;
        #2;
        chk("post rst busy", 32'(md_busy), 0);
        chk("post rst stall", 32'(stall), 0);

        tick();
        clr();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WR = 5'd4; ID_src = {5'd4, 5'd0}; ID_use = 2'b10;
        repeat (5) tick();
        clr();
        #2;
        chk("sat cnt w2", 32'(stall_cnt2), 3);
        chk("sat cnt w16", 32'(stall_cnt), 5);

        repeat (600) begin
            tick();
            for (int i = 0; i < NS; i++) begin
                ID_src[i*AW +: AW] = AW'($urandom_range(0, 7));
                EX_src[i*AW +: AW] = AW'($urandom_range(0, 7));
            end
            for (int k = 0; k < NF; k++) FWD_WR[k*AW +: AW] = AW'($urandom_range(0, 7));
            ID_use       = NS'($urandom);
            FWD_RegWrite = NF'($urandom);
            ID_is_md     = $urandom_range(0, 3) == 0;
            EX_RegWrite  = $urandom_range(0, 1) == 0;
            EX_MemRead   = $urandom_range(0, 2) == 0;
            EX_WR        = AW'($urandom_range(0, 7));
            EX_md_start  = $urandom_range(0, 7) == 0;
        end
        tick();
        clr();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
